// File: rtl/usb_cdc_rx_fifo.sv
// usb_cdc_rx_fifo
//   Byte FIFO between the USB CDC core OUT stream and the application.
//   It absorbs host bursts so the application can drain at its own pace.
//   It is first-word fall-through, with one push and one pop per cycle sustained.
//
// Ports
//   clk_i, rst_i          single clock, synchronous active-high reset
//   s_data_i/s_valid_i    byte from the CDC core (out_data_o / out_valid_o)
//   s_ready_o             to the CDC core out_ready_i, high when not full
//   m_data_o/m_valid_o    head byte to the application (zero when empty)
//   m_ready_i             application accepts the head byte
//   empty_o, full_o       occupancy flags
//   level_o               occupancy count, only when USB_CDC_RX_FIFO_LEVEL_EN
//                         is defined
//
// Parameters
//   DATA_W      byte width, must match the CDC core out data width
//   DEPTH_LOG2  log2 of entry count, legal range 1..6
module usb_cdc_rx_fifo #(
  parameter int DATA_W     = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] s_data_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  output logic [DATA_W-1:0] m_data_o,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic              empty_o,
  output logic              full_o
`ifdef USB_CDC_RX_FIFO_LEVEL_EN
  ,
  output logic [DEPTH_LOG2:0] level_o
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  // Storage is not reset. Reads of stale entries are masked by m_valid_o.
  logic [DATA_W-1:0] mem [DEPTH];

  // The MSB of each pointer is a wrap bit. It separates full from empty
  // when the index bits match.
  logic [DEPTH_LOG2:0]   wr_ptr, rd_ptr;
  logic [DEPTH_LOG2-1:0] wr_idx, rd_idx;
  logic                  push, pop;

  assign wr_idx = wr_ptr[DEPTH_LOG2-1:0];
  assign rd_idx = rd_ptr[DEPTH_LOG2-1:0];

  // The flags are decoded only from registered pointers. This means neither
  // ready nor valid depends combinationally on the other side's handshake.
  assign empty_o   = (wr_ptr == rd_ptr);
  assign full_o    = (wr_idx == rd_idx) && (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]);
  assign s_ready_o = !full_o;
  assign m_valid_o = !empty_o;

  assign push = s_valid_i && s_ready_o;
  assign pop  = m_valid_o && m_ready_i;

  assign m_data_o = m_valid_o ? mem[rd_idx] : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // The write is gated by rst_i so a byte presented during reset never lands.
  // It could not be seen anyway, since the pointers clear.
  always_ff @(posedge clk_i) begin
    if (push && !rst_i) mem[wr_idx] <= s_data_i;
  end

`ifdef USB_CDC_RX_FIFO_LEVEL_EN
  // Modulo subtraction on the wrap-extended pointers gives 0..DEPTH directly.
  assign level_o = wr_ptr - rd_ptr;
`endif

endmodule

// File: tb/tb_usb_cdc_rx_fifo.sv
// Directed testbench for usb_cdc_rx_fifo (DATA_W=8, DEPTH_LOG2=4).
// Level checks are compiled in only when USB_CDC_RX_FIFO_LEVEL_EN is defined.
module tb_usb_cdc_rx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       empty;
  logic       full;
`ifdef USB_CDC_RX_FIFO_LEVEL_EN
  logic [4:0] level;
`endif

  int vec_cnt = 0;
  int err_cnt = 0;

  // {s_ready, m_valid, empty, full}
  logic [3:0] st;
  assign st = {s_ready, m_valid, empty, full};

  localparam logic [3:0] ST_EMPTY = 4'b1010;
  localparam logic [3:0] ST_MID   = 4'b1100;
  localparam logic [3:0] ST_FULL  = 4'b0101;

  usb_cdc_rx_fifo #(.DATA_W(8), .DEPTH_LOG2(4)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .s_data_i (s_data),
    .s_valid_i(s_valid),
    .s_ready_o(s_ready),
    .m_data_o (m_data),
    .m_valid_o(m_valid),
    .m_ready_i(m_ready),
    .empty_o  (empty),
    .full_o   (full)
`ifdef USB_CDC_RX_FIFO_LEVEL_EN
    ,
    .level_o  (level)
`endif
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; s_valid = 1'b0; s_data = 8'h00; m_ready = 1'b0;
    tick; tick;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      vec_cnt++;
      if (st !== ST_EMPTY || m_data !== 8'h00) begin
        err_cnt++;
        $display("FAIL reset_idle cyc %0d: st=%b data=%h want st=%b data=00", i, st, m_data, ST_EMPTY);
      end
`ifdef USB_CDC_RX_FIFO_LEVEL_EN
      vec_cnt++;
      if (level !== 5'd0) begin
        err_cnt++;
        $display("FAIL reset_level cyc %0d: got %0d want 0", i, level);
      end
`endif
      tick;
    end
  endtask

  task automatic test_single;
    s_data = 8'hA5; s_valid = 1'b1; m_ready = 1'b0;
    tick;
    s_valid = 1'b0;
    vec_cnt++;
    if (st !== ST_MID || m_data !== 8'hA5) begin
      err_cnt++;
      $display("FAIL single_push: st=%b data=%h want st=%b data=a5", st, m_data, ST_MID);
    end
`ifdef USB_CDC_RX_FIFO_LEVEL_EN
    vec_cnt++;
    if (level !== 5'd1) begin
      err_cnt++;
      $display("FAIL single_level: got %0d want 1", level);
    end
`endif
    m_ready = 1'b1;
    tick;
    m_ready = 1'b0;
    vec_cnt++;
    if (st !== ST_EMPTY || m_data !== 8'h00) begin
      err_cnt++;
      $display("FAIL single_pop: st=%b data=%h want st=%b data=00", st, m_data, ST_EMPTY);
    end
  endtask

  task automatic test_fill;
    m_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      s_data = 8'(i); s_valid = 1'b1;
      tick;
    end
    // The 17th byte stays presented while the FIFO is full.
    s_data = 8'h10;
    vec_cnt++;
    if (st !== ST_FULL || m_data !== 8'h00) begin
      err_cnt++;
      $display("FAIL fill_full: st=%b data=%h want st=%b data=00", st, m_data, ST_FULL);
    end
`ifdef USB_CDC_RX_FIFO_LEVEL_EN
    vec_cnt++;
    if (level !== 5'd16) begin
      err_cnt++;
      $display("FAIL fill_level: got %0d want 16", level);
    end
`endif
    tick;
    vec_cnt++;
    if (st !== ST_FULL || m_data !== 8'h00) begin
      err_cnt++;
      $display("FAIL fill_hold: st=%b data=%h want st=%b data=00", st, m_data, ST_FULL);
    end
    m_ready = 1'b1;
    tick;  // pop 0x00; the push is still blocked this cycle
    m_ready = 1'b0;
    vec_cnt++;
    if (st !== ST_MID || m_data !== 8'h01) begin
      err_cnt++;
      $display("FAIL fill_ready_rise: st=%b data=%h want st=%b data=01", st, m_data, ST_MID);
    end
`ifdef USB_CDC_RX_FIFO_LEVEL_EN
    vec_cnt++;
    if (level !== 5'd15) begin
      err_cnt++;
      $display("FAIL fill_level_after_pop: got %0d want 15", level);
    end
`endif
    tick;  // 0x10 accepted
    s_valid = 1'b0;
    vec_cnt++;
    if (st !== ST_FULL) begin
      err_cnt++;
      $display("FAIL fill_refull: st=%b want %b", st, ST_FULL);
    end
    m_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      vec_cnt++;
      if (m_valid !== 1'b1 || m_data !== 8'(i)) begin
        err_cnt++;
        $display("FAIL fill_drain %0d: valid=%b data=%h want valid=1 data=%h", i, m_valid, m_data, 8'(i));
      end
      tick;
    end
    m_ready = 1'b0;
    vec_cnt++;
    if (st !== ST_EMPTY || m_data !== 8'h00) begin
      err_cnt++;
      $display("FAIL fill_drained: st=%b data=%h want st=%b data=00", st, m_data, ST_EMPTY);
    end
  endtask

  task automatic test_stream;
    m_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      s_data = 8'(i); s_valid = 1'b1;
      tick;
      vec_cnt++;
      if (st !== ST_MID || m_data !== 8'(i)) begin
        err_cnt++;
        $display("FAIL stream %0d: st=%b data=%h want st=%b data=%h", i, st, m_data, ST_MID, 8'(i));
      end
`ifdef USB_CDC_RX_FIFO_LEVEL_EN
      vec_cnt++;
      if (level !== 5'd1) begin
        err_cnt++;
        $display("FAIL stream_level %0d: got %0d want 1", i, level);
      end
`endif
    end
    s_valid = 1'b0;
    tick;
    m_ready = 1'b0;
    vec_cnt++;
    if (st !== ST_EMPTY) begin
      err_cnt++;
      $display("FAIL stream_end: st=%b want %b", st, ST_EMPTY);
    end
  endtask

  task automatic test_random;
    logic [7:0] q[$];
    logic [7:0] exp_data;
    logic       push, pop;
    int         sent = 0;
    int         got  = 0;
    s_valid = 1'b0; m_ready = 1'b0;
    for (int cyc = 0; cyc < 6000 && got < 500; cyc++) begin
      // A byte that is not yet accepted stays presented unchanged.
      if (!s_valid && sent < 500 && $urandom_range(0, 1) == 1) begin
        s_valid = 1'b1;
        s_data  = 8'($urandom);
      end
      m_ready = 1'($urandom_range(0, 1));
      push = s_valid && (q.size() < 16);
      pop  = m_ready && (q.size() > 0);
      tick;
      if (pop) begin
        void'(q.pop_front());
        got++;
      end
      if (push) begin
        q.push_back(s_data);
        sent++;
        s_valid = 1'b0;
      end
      exp_data = (q.size() > 0) ? q[0] : 8'h00;
      vec_cnt++;
      if (m_valid !== (q.size() > 0) || full !== (q.size() == 16) || m_data !== exp_data) begin
        err_cnt++;
        $display("FAIL random cyc %0d: valid=%b full=%b data=%h want valid=%b full=%b data=%h",
                 cyc, m_valid, full, m_data, q.size() > 0, q.size() == 16, exp_data);
      end
`ifdef USB_CDC_RX_FIFO_LEVEL_EN
      vec_cnt++;
      if (level !== 5'(q.size())) begin
        err_cnt++;
        $display("FAIL random_level cyc %0d: got %0d want %0d", cyc, level, q.size());
      end
`endif
    end
    s_valid = 1'b0; m_ready = 1'b0;
    vec_cnt++;
    if (got !== 500 || sent !== 500) begin
      err_cnt++;
      $display("FAIL random_complete: sent=%0d got=%0d want 500/500", sent, got);
    end
  endtask

  task automatic test_reset_mid;
    m_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      s_data = 8'(8'h30 + i); s_valid = 1'b1;
      tick;
    end
    s_valid = 1'b0;
    vec_cnt++;
    if (st !== ST_MID || m_data !== 8'h30) begin
      err_cnt++;
      $display("FAIL rstmid_pre: st=%b data=%h want st=%b data=30", st, m_data, ST_MID);
    end
`ifdef USB_CDC_RX_FIFO_LEVEL_EN
    vec_cnt++;
    if (level !== 5'd7) begin
      err_cnt++;
      $display("FAIL rstmid_pre_level: got %0d want 7", level);
    end
`endif
    rst = 1'b1; s_data = 8'hEE; s_valid = 1'b1;
    tick;
    rst = 1'b0; s_valid = 1'b0;
    vec_cnt++;
    if (st !== ST_EMPTY || m_data !== 8'h00) begin
      err_cnt++;
      $display("FAIL rstmid_post: st=%b data=%h want st=%b data=00", st, m_data, ST_EMPTY);
    end
`ifdef USB_CDC_RX_FIFO_LEVEL_EN
    vec_cnt++;
    if (level !== 5'd0) begin
      err_cnt++;
      $display("FAIL rstmid_level: got %0d want 0", level);
    end
`endif
    tick;
    vec_cnt++;
    if (st !== ST_EMPTY) begin
      err_cnt++;
      $display("FAIL rstmid_no_store: st=%b want %b", st, ST_EMPTY);
    end
    // After reset the first push lands at the head, since the pointers restart at zero.
    s_data = 8'h77; s_valid = 1'b1;
    tick;
    s_valid = 1'b0;
    vec_cnt++;
    if (st !== ST_MID || m_data !== 8'h77) begin
      err_cnt++;
      $display("FAIL rstmid_restart: st=%b data=%h want st=%b data=77", st, m_data, ST_MID);
    end
    m_ready = 1'b1;
    tick;
    m_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = 8'h00; m_ready = 1'b0;
    test_reset;
    test_single;
    test_fill;
    test_stream;
    test_random;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
